execute_stage: RTL

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// Execute stage of a 5-stage MIPS-style pipeline: operand forwarding, ALU,
// a sequential shift-add multiplier that stalls the front end, and the E/M register.
module execute_stage #(
  parameter int WIDTH             = 32,
  parameter int ALU_Control_width = 3,
  parameter int Reg_width         = 5
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [ALU_Control_width-1:0] ALUControlE,
  input  logic                         RegWriteE,
  input  logic                         MemtoRegE,
  input  logic                         MemWriteE,
  input  logic                         RegDstE,
  input  logic                         ALUSrcE,
  input  logic                         MulE,
  input  logic [WIDTH-1:0]             RD1_E,
  input  logic [WIDTH-1:0]             RD2_E,
  input  logic [WIDTH-1:0]             SignImmE,
  input  logic [Reg_width-1:0]         RtE,
  input  logic [Reg_width-1:0]         RdE,
  input  logic [1:0]                   ForwardAE,
  input  logic [1:0]                   ForwardBE,
  input  logic [WIDTH-1:0]             ResultW,
  output logic                         StallMul,
  output logic                         RegWriteM,
  output logic                         MemtoRegM,
  output logic                         MemWriteM,
  output logic [WIDTH-1:0]             ALUOutM,
  output logic [WIDTH-1:0]             WriteDataM,
  output logic [Reg_width-1:0]         WriteRegM
);

  localparam logic [ALU_Control_width-1:0] ALU_AND = ALU_Control_width'(3'b000);
  localparam logic [ALU_Control_width-1:0] ALU_OR  = ALU_Control_width'(3'b001);
  localparam logic [ALU_Control_width-1:0] ALU_ADD = ALU_Control_width'(3'b010);
  localparam logic [ALU_Control_width-1:0] ALU_SUB = ALU_Control_width'(3'b110);
  localparam logic [ALU_Control_width-1:0] ALU_SLT = ALU_Control_width'(3'b111);
  localparam logic [4:0]                   LAST_STEP = 5'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t           state_reg, state_next;
  logic [4:0]           count_reg, count_next;
  logic [WIDTH-1:0]     mcand_reg, mcand_next;
  logic [WIDTH-1:0]     mplier_reg, mplier_next;
  logic [WIDTH-1:0]     acc_reg, acc_next;

  logic [WIDTH-1:0]     src_a, fwd_b, src_b, alu_result;
  logic [Reg_width-1:0] write_reg_e;
  logic                 stall;

  logic                 reg_write_next, mem_to_reg_next, mem_write_next;
  logic [WIDTH-1:0]     alu_out_next, write_data_next;
  logic [Reg_width-1:0] write_reg_next;

  // Select 2'b11 falls through to the register-file value.
  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUOutM;
      default: src_a = RD1_E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUOutM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b       = ALUSrcE ? SignImmE : fwd_b;
  assign write_reg_e = RegDstE ? RdE : RtE;

  always_comb begin
    case (ALUControlE)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    mcand_next      = mcand_reg;
    mplier_next     = mplier_reg;
    acc_next        = acc_reg;
    stall           = 1'b0;
    reg_write_next  = RegWriteE;
    mem_to_reg_next = MemtoRegE;
    mem_write_next  = MemWriteE;
    alu_out_next    = alu_result;
    write_data_next = fwd_b;
    write_reg_next  = write_reg_e;

    case (state_reg)
      IDLE: begin
        if (MulE) begin
          stall           = 1'b1;
          mcand_next      = src_a;
          mplier_next     = src_b;
          acc_next        = '0;
          count_next      = '0;
          reg_write_next  = 1'b0;
          mem_to_reg_next = 1'b0;
          mem_write_next  = 1'b0;
          alu_out_next    = '0;
          write_data_next = '0;
          write_reg_next  = '0;
          state_next      = BUSY;
        end
      end
      BUSY: begin
        stall           = 1'b1;
        if (mplier_reg[0]) acc_next = acc_reg + mcand_reg;
        mcand_next      = mcand_reg << 1;
        mplier_next     = mplier_reg >> 1;
        count_next      = count_reg + 5'd1;
        reg_write_next  = 1'b0;
        mem_to_reg_next = 1'b0;
        mem_write_next  = 1'b0;
        alu_out_next    = '0;
        write_data_next = '0;
        write_reg_next  = '0;
        if (count_reg == LAST_STEP) state_next = DONE;
      end
      DONE: begin
        // Operands were frozen by the stall, so the control bits still belong to the multiply.
        alu_out_next = acc_reg;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign StallMul = stall & ~RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WriteRegM  <= '0;
    end else begin
      RegWriteM  <= reg_write_next;
      MemtoRegM  <= mem_to_reg_next;
      MemWriteM  <= mem_write_next;
      ALUOutM    <= alu_out_next;
      WriteDataM <= write_data_next;
      WriteRegM  <= write_reg_next;
    end
  end

endmodule
